branch_predictor: RTL

- Parametrised dynamic branch predictor for the pipelined RV32I core; replaces the stall-on-every-branch policy in IF.
- Combinational lookup of the IF-stage PC returns a taken/target prediction in the same cycle.
- Registered update from EX trains the tables once a control-flow instruction resolves.
- Direct-mapped tagged BTB plus a saturating-counter pattern table, selectable bimodal or gshare, with saturating performance counters.

---
 rtl/branch_predictor_pkg.sv | 30 +++
 rtl/bp_btb.sv | 63 ++++++
 rtl/branch_predictor.sv | 125 ++++++++++++
 3 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: indexing modes, counter
// constants and a constant log2 helper used to size index fields.
package branch_predictor_pkg;

    localparam int BP_BIMODAL = 0;
    localparam int BP_GSHARE  = 1;

    // Smallest n with 2**n >= value; used only on power-of-two depths.
    function automatic int bp_log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Saturation ceiling of a width-bit counter (strongly taken).
    function automatic int bp_cnt_max(input int width);
        return (1 << width) - 1;
    endfunction

    // Reset value of a width-bit counter (weakly not-taken).
    function automatic int bp_cnt_rst(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped tagged branch target buffer. Read is combinational from the
// stored arrays; writes land on the rising edge and overwrite whatever entry
// occupies the slot. Only the valid bits are reset; tag/target/uncond are
// qualified by valid and so need no reset.
module bp_btb
    import branch_predictor_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] rd_pc,
    output logic            rd_hit,
    output logic            rd_uncond,
    output logic [XLEN-1:0] rd_target,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wr_pc,
    input  logic [XLEN-1:0] wr_target,
    input  logic            wr_uncond
);

    localparam int IDX_W = bp_log2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] uncond_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [TAG_W-1:0] wr_tag;

    assign rd_idx = rd_pc[IDX_W+1:2];
    assign rd_tag = rd_pc[XLEN-1:IDX_W+2];
    assign wr_idx = wr_pc[IDX_W+1:2];
    assign wr_tag = wr_pc[XLEN-1:IDX_W+2];

    assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_uncond = uncond_q[rd_idx];
    assign rd_target = target_q[rd_idx];

    // Valid bits: cleared asynchronously, set when an entry is allocated.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Entry payload: written alongside the valid bit, never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= wr_target;
            uncond_q[wr_idx] <= wr_uncond;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor for the RV32I fetch stage: zero-latency lookup of
// the fetch PC against a tagged BTB and a saturating-counter table (bimodal or
// gshare indexed), trained by resolved control-flow instructions from EX.
// Lookups always see pre-update state; there is no write-to-read bypass.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int  XLEN        = 32,
    parameter int  BTB_ENTRIES = 16,
    parameter int  BHT_ENTRIES = 64,
    parameter int  CNT_W       = 2,
    parameter int  MODE        = BP_BIMODAL,
    localparam int BHT_BITS    = bp_log2(BHT_ENTRIES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [XLEN-1:0]     pred_pc,
    output logic                pred_taken,
    output logic [XLEN-1:0]     pred_target,
    output logic [BHT_BITS-1:0] pred_index,
    input  logic                upd_valid,
    input  logic                upd_uncond,
    input  logic [XLEN-1:0]     upd_pc,
    input  logic [BHT_BITS-1:0] upd_index,
    input  logic                upd_taken,
    input  logic [XLEN-1:0]     upd_target,
    input  logic                upd_mispredict,
    output logic [31:0]         cnt_branches,
    output logic [31:0]         cnt_mispredicts
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(bp_cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(bp_cnt_rst(CNT_W));

    logic [CNT_W-1:0]    cnt_q [BHT_ENTRIES];
    logic [BHT_BITS-1:0] ghr_q;
    logic [31:0]         branches_q;
    logic [31:0]         mispredicts_q;

    logic [BHT_BITS-1:0] hist_mix;
    logic [BHT_BITS-1:0] bht_idx;
    logic                btb_hit;
    logic                btb_uncond;
    logic [XLEN-1:0]     btb_target;
    logic [CNT_W-1:0]    cnt_cur;
    logic [CNT_W-1:0]    cnt_nxt;

    bp_btb #(
        .XLEN    (XLEN),
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk       (clk),
        .reset     (reset),
        .rd_pc     (pred_pc),
        .rd_hit    (btb_hit),
        .rd_uncond (btb_uncond),
        .rd_target (btb_target),
        .wr_en     (upd_valid && upd_taken),
        .wr_pc     (upd_pc),
        .wr_target (upd_target),
        .wr_uncond (upd_uncond)
    );

    // Bimodal ignores history; gshare folds the global history into the index.
    assign hist_mix = (MODE == BP_GSHARE) ? ghr_q : '0;
    assign bht_idx  = pred_pc[BHT_BITS+1:2] ^ hist_mix;

    assign pred_index  = bht_idx;
    assign pred_taken  = btb_hit && (btb_uncond || cnt_q[bht_idx][CNT_W-1]);
    assign pred_target = btb_hit ? btb_target : (pred_pc + XLEN'(4));

    assign cnt_branches    = branches_q;
    assign cnt_mispredicts = mispredicts_q;

    // Next value of the trained counter: jumps pin it strong, branches saturate.
    always_comb begin
        cnt_cur = cnt_q[upd_index];
        cnt_nxt = cnt_cur;
        if (upd_uncond) begin
            cnt_nxt = CNT_MAX;
        end else if (upd_taken) begin
            if (cnt_cur != CNT_MAX) begin
                cnt_nxt = cnt_cur + CNT_W'(1);
            end
        end else if (cnt_cur != '0) begin
            cnt_nxt = cnt_cur - CNT_W'(1);
        end
    end

    // Pattern table: reset weakly not-taken, train the entry captured at fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                cnt_q[i] <= CNT_RST;
            end
        end else if (upd_valid) begin
            cnt_q[upd_index] <= cnt_nxt;
        end
    end

    // Global history: conditional outcomes only, newest in the LSB.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr_q <= '0;
        end else if (upd_valid && !upd_uncond && (MODE == BP_GSHARE)) begin
            ghr_q <= BHT_BITS'({ghr_q, upd_taken});
        end
    end

    // Performance counters, saturating at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branches_q    <= '0;
            mispredicts_q <= '0;
        end else if (upd_valid) begin
            if (branches_q != '1) begin
                branches_q <= branches_q + 32'd1;
            end
            if (upd_mispredict && (mispredicts_q != '1)) begin
                mispredicts_q <= mispredicts_q + 32'd1;
            end
        end
    end

endmodule
